// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, tracking-entry layout and parameter checks for pipe_ctrl.
package pipe_ctrl_pkg;

   localparam int unsigned STG_F     = 0;
   localparam int unsigned STG_D     = 1;
   localparam int unsigned STG_E     = 2;
   localparam int unsigned TAG_MAX_W = 8;

   typedef logic [TAG_MAX_W-1:0] tag_t;

   // Tags are zero-extended to TAG_MAX_W so one layout serves every REG_AW.
   typedef struct packed {
      logic valid;
      logic regwrite;
      logic memtoreg;
      tag_t writereg;
      tag_t rs;
      tag_t rt;
   } entry_t;

   function automatic logic params_legal(input int unsigned num_stages,
                                         input int unsigned reg_aw,
                                         input int unsigned load_stage);
      return (num_stages >= 4) && (num_stages <= 8) &&
             (reg_aw >= 1) && (reg_aw <= TAG_MAX_W) &&
             (load_stage >= STG_E) && (load_stage <= num_stages - 2);
   endfunction

   function automatic logic tag_match(input entry_t e, input tag_t tag);
      return e.valid & e.regwrite & (tag != '0) & (e.writereg == tag);
   endfunction

endpackage

// File: rtl/pipe_ctrl_entry.sv
// One in-flight instruction tracking register: sync reset, clear beats hold.
module pipe_ctrl_entry
   import pipe_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_en,
   input  logic   i_clr,
   input  entry_t i_d,
   output entry_t o_q
);

   entry_t r_q;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/forwarding control: per-stage stall/flush and forwarding selects.
// Define PIPE_CTRL_DELAY_SLOT_EN to keep the branch delay slot (redirect never flushes D).
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned LOAD_STAGE = 3,
   parameter int unsigned FW         = $clog2(NUM_STAGES - 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_AW-1:0]     id_rs,
   input  logic [REG_AW-1:0]     id_rt,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic                  id_regwrite,
   input  logic [REG_AW-1:0]     id_writereg,
   input  logic                  id_memtoreg,
   input  logic                  id_branch,
   input  logic                  redirect,
   input  logic                  ex_busy,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] flush,
   output logic                  fwd_a_d,
   output logic                  fwd_b_d,
   output logic [FW-1:0]         fwd_a_e,
   output logic [FW-1:0]         fwd_b_e
);

   if (!params_legal(NUM_STAGES, REG_AW, LOAD_STAGE)) begin : g_bad_params
      $error("pipe_ctrl: illegal NUM_STAGES/REG_AW/LOAD_STAGE combination");
   end

   entry_t                w_ent [NUM_STAGES-1:STG_E];
   entry_t                w_dec;
   logic [NUM_STAGES-1:0] w_stall;
   logic [NUM_STAGES-1:0] w_flush;
   logic                  w_lwstall;
   logic                  w_brstall;
   logic                  w_src_hit;
   logic                  w_fwd_ok;
   logic [FW-1:0]         w_fwd_a_e;
   logic [FW-1:0]         w_fwd_b_e;
   logic                  w_fwd_a_d;
   logic                  w_fwd_b_d;
   logic                  w_unused_last;

   // Unused sources are recorded as tag 0 so they can never match a producer.
   assign w_dec = '{valid:    1'b1,
                    regwrite: id_regwrite,
                    memtoreg: id_memtoreg,
                    writereg: TAG_MAX_W'(id_writereg),
                    rs:       id_rs_used ? TAG_MAX_W'(id_rs) : '0,
                    rt:       id_rt_used ? TAG_MAX_W'(id_rt) : '0};

   for (genvar s = STG_E; s < NUM_STAGES; s++) begin : g_ent
      entry_t w_d;
      if (s == STG_E) begin : g_first
         assign w_d = w_dec;
      end else begin : g_rest
         assign w_d = w_ent[s-1];
      end
      pipe_ctrl_entry u_entry (
         .clk   (clk),
         .rst   (rst),
         .i_en  (~w_stall[s]),
         .i_clr (w_flush[s]),
         .i_d   (w_d),
         .o_q   (w_ent[s])
      );
   end

   assign w_unused_last = ^{w_ent[NUM_STAGES-1].rs, w_ent[NUM_STAGES-1].rt};

   // Load-use and branch-operand interlocks against every tracked producer.
   always_comb begin
      w_lwstall = 1'b0;
      w_brstall = 1'b0;
      w_src_hit = 1'b0;
      for (int unsigned s = STG_E; s < NUM_STAGES; s++) begin
         w_src_hit = tag_match(w_ent[s], w_dec.rs) | tag_match(w_ent[s], w_dec.rt);
         if (w_src_hit && w_ent[s].memtoreg && (s < LOAD_STAGE)) begin
            w_lwstall = 1'b1;
         end
         if (w_src_hit && id_branch &&
             ((s == STG_E) || (w_ent[s].memtoreg && (s <= LOAD_STAGE)))) begin
            w_brstall = 1'b1;
         end
      end
   end

   // Divider back-pressure outranks interlocks; redirect only acts on a moving D.
   always_comb begin
      w_stall = '0;
      w_flush = '0;
      if (ex_busy) begin
         w_stall[STG_E:STG_F]   = '1;
         w_flush[STG_E+1]       = 1'b1;
      end else if (w_lwstall || w_brstall) begin
         w_stall[STG_D:STG_F]   = '1;
         w_flush[STG_E]         = 1'b1;
      end
`ifndef PIPE_CTRL_DELAY_SLOT_EN
      if (redirect && !w_stall[STG_D]) begin
         w_flush[STG_D] = 1'b1;
      end
`endif
      if (rst) begin
         w_stall = '0;
         w_flush = '1;
      end
   end

   // Walk oldest to youngest so the nearest eligible producer wins.
   always_comb begin
      w_fwd_a_e = '0;
      w_fwd_b_e = '0;
      w_fwd_ok  = 1'b0;
      for (int unsigned s = NUM_STAGES - 1; s > STG_E; s--) begin
         w_fwd_ok = !(w_ent[s].memtoreg && (s <= LOAD_STAGE));
         if (w_fwd_ok && tag_match(w_ent[s], w_ent[STG_E].rs)) begin
            w_fwd_a_e = FW'(s - STG_E);
         end
         if (w_fwd_ok && tag_match(w_ent[s], w_ent[STG_E].rt)) begin
            w_fwd_b_e = FW'(s - STG_E);
         end
      end
   end

   assign w_fwd_a_d = tag_match(w_ent[STG_E+1], TAG_MAX_W'(id_rs)) & ~w_ent[STG_E+1].memtoreg;
   assign w_fwd_b_d = tag_match(w_ent[STG_E+1], TAG_MAX_W'(id_rt)) & ~w_ent[STG_E+1].memtoreg;

   assign stall   = w_stall;
   assign flush   = w_flush;
   assign fwd_a_e = rst ? '0 : w_fwd_a_e;
   assign fwd_b_e = rst ? '0 : w_fwd_b_e;
   assign fwd_a_d = ~rst & w_fwd_a_d;
   assign fwd_b_d = ~rst & w_fwd_b_d;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard sequences then random traffic
// against a pipeline-occupancy reference model.
module tb_pipe_ctrl;

   localparam int NS  = 5;
   localparam int AW  = 5;
   localparam int LS  = 3;
   localparam int FWB = $clog2(NS - 2);
   localparam int E   = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   id_rs, id_rt, id_writereg;
   logic            id_rs_used, id_rt_used, id_regwrite, id_memtoreg, id_branch;
   logic            redirect, ex_busy;
   logic [NS-1:0]   stall, flush;
   logic            fwd_a_d, fwd_b_d;
   logic [FWB-1:0]  fwd_a_e, fwd_b_e;

   pipe_ctrl #(.NUM_STAGES(NS), .REG_AW(AW), .LOAD_STAGE(LS), .FW(FWB)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_regwrite(id_regwrite), .id_writereg(id_writereg), .id_memtoreg(id_memtoreg),
      .id_branch(id_branch), .redirect(redirect), .ex_busy(ex_busy),
      .stall(stall), .flush(flush), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          rsu;
      logic          rtu;
      logic          rw;
      logic [AW-1:0] wr;
      logic          ld;
      logic          br;
   } din_t;

   typedef struct packed {
      logic [NS-1:0]  stall;
      logic [NS-1:0]  flush;
      logic           fad;
      logic           fbd;
      logic [FWB-1:0] fae;
      logic [FWB-1:0] fbe;
   } exp_t;

   // Model: which instruction occupies each stage E..last (v=0 is a bubble).
   typedef struct {
      bit v;
      bit rw;
      bit ld;
      int wr;
      int rs;
      int rt;
   } ins_t;

   ins_t m_st [NS];
   exp_t q [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Stage at which a producer's result first becomes usable by a consumer.
   function automatic int ready_at(input ins_t p);
      return p.ld ? LS + 1 : E + 1;
   endfunction

   function automatic bit produces(input ins_t p, input int tag);
      return p.v && p.rw && (tag != 0) && (p.wr == tag);
   endfunction

   function automatic int fwd_sel(input int tag);
      for (int d = 1; d <= NS - 1 - E; d++) begin
         if (produces(m_st[E+d], tag) && (E + d >= ready_at(m_st[E+d]))) return d;
      end
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Drive one cycle, predict the response, then advance the model across the edge.
   task automatic step(input logic rst_v, input din_t d, input logic redir,
                       input logic busy, output bit stalled);
      exp_t e;
      bit   hz;
      int   src [2];
      ins_t nxt [NS];
      ins_t bub;
      bub = '{v:0, rw:0, ld:0, wr:0, rs:0, rt:0};
      rst = rst_v; id_rs = d.rs; id_rt = d.rt; id_rs_used = d.rsu; id_rt_used = d.rtu;
      id_regwrite = d.rw; id_writereg = d.wr; id_memtoreg = d.ld; id_branch = d.br;
      redirect = redir; ex_busy = busy;
      src[0] = d.rsu ? int'(d.rs) : 0;
      src[1] = d.rtu ? int'(d.rt) : 0;
      hz = 1'b0;
      for (int s = E; s < NS; s++) begin
         for (int k = 0; k < 2; k++) begin
            if (produces(m_st[s], src[k])) begin
               if (s + 1 < ready_at(m_st[s])) hz = 1'b1;
               if (d.br && (s < ready_at(m_st[s]))) hz = 1'b1;
            end
         end
      end
      e = '0;
      if (rst_v) begin
         e.flush = '1;
      end else begin
         if (hz || busy) begin
            e.stall[0] = 1'b1;
            e.stall[1] = 1'b1;
         end
         if (busy) begin
            e.stall[E]   = 1'b1;
            e.flush[E+1] = 1'b1;
         end else if (hz) begin
            e.flush[E] = 1'b1;
         end
`ifndef PIPE_CTRL_DELAY_SLOT_EN
         if (redir && !e.stall[1]) e.flush[1] = 1'b1;
`endif
         e.fae = FWB'(fwd_sel(m_st[E].rs));
         e.fbe = FWB'(fwd_sel(m_st[E].rt));
         e.fad = produces(m_st[E+1], int'(d.rs)) && (ready_at(m_st[E+1]) <= E + 1);
         e.fbd = produces(m_st[E+1], int'(d.rt)) && (ready_at(m_st[E+1]) <= E + 1);
      end
      q.push_back(e);
      stalled = e.stall[1];
      for (int s = 0; s < NS; s++) nxt[s] = bub;
      if (!rst_v) begin
         for (int s = E + 1; s < NS; s++) nxt[s] = m_st[s-1];
         if (busy) begin
            nxt[E]   = m_st[E];
            nxt[E+1] = bub;
         end else if (!hz) begin
            nxt[E] = '{v:1, rw:d.rw, ld:d.ld, wr:int'(d.wr), rs:src[0], rt:src[1]};
         end
      end
      m_st = nxt;
      @(posedge clk);
      #1;
   endtask

   // Present an instruction in D until it leaves D (stall drops).
   task automatic issue(input din_t d, input logic redir);
      bit st;
      int n;
      n = 0;
      do begin
         step(1'b0, d, redir, 1'b0, st);
         n++;
      end while (st && n < 8);
   endtask

   function automatic din_t alu(input int wr, input int rs, input int rt);
      din_t d;
      d = '0;
      d.rs = AW'(rs); d.rt = AW'(rt); d.rsu = 1'b1; d.rtu = 1'b1;
      d.rw = 1'b1; d.wr = AW'(wr);
      return d;
   endfunction

   function automatic din_t lw(input int wr, input int base);
      din_t d;
      d = '0;
      d.rs = AW'(base); d.rt = AW'(wr); d.rsu = 1'b1;
      d.rw = 1'b1; d.wr = AW'(wr); d.ld = 1'b1;
      return d;
   endfunction

   function automatic din_t beq(input int rs, input int rt);
      din_t d;
      d = '0;
      d.rs = AW'(rs); d.rt = AW'(rt); d.rsu = 1'b1; d.rtu = 1'b1; d.br = 1'b1;
      return d;
   endfunction

   // Monitor: the DUT answers every cycle, so compare whenever a prediction is queued.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("stall",   32'(stall),   32'(e.stall));
         chk("flush",   32'(flush),   32'(e.flush));
         chk("fwd_a_e", 32'(fwd_a_e), 32'(e.fae));
         chk("fwd_b_e", 32'(fwd_b_e), 32'(e.fbe));
         chk("fwd_a_d", 32'(fwd_a_d), 32'(e.fad));
         chk("fwd_b_d", 32'(fwd_b_d), 32'(e.fbd));
         cyc++;
      end
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      din_t nop;
      din_t cur;
      bit   st;
      bit   b;
      int   busy_left;
      nop = '0;
      cur = '0;
      st = 1'b0;
      busy_left = 0;
      rst = 1'b1; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
      id_regwrite = 1'b0; id_writereg = '0; id_memtoreg = 1'b0; id_branch = 1'b0;
      redirect = 1'b0; ex_busy = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, nop, 1'b0, 1'b0, st);
      step(1'b1, nop, 1'b0, 1'b0, st);

      // back-to-back and two-apart ALU forwarding
      issue(alu(3, 1, 2), 1'b0); issue(alu(6, 3, 1), 1'b0); issue(nop, 1'b0);
      issue(alu(3, 1, 2), 1'b0); issue(nop, 1'b0); issue(alu(7, 3, 3), 1'b0);
      issue(nop, 1'b0); issue(nop, 1'b0);
      // load-use
      issue(lw(5, 1), 1'b0); issue(alu(8, 5, 2), 1'b0);
      repeat (3) issue(nop, 1'b0);
      // branch operand interlocks
      issue(alu(4, 1, 2), 1'b0); issue(beq(4, 0), 1'b0);
      repeat (3) issue(nop, 1'b0);
      issue(lw(4, 1), 1'b0); issue(beq(4, 0), 1'b0);
      repeat (3) issue(nop, 1'b0);
      // divider back-pressure for three cycles
      issue(alu(9, 1, 2), 1'b0); issue(alu(10, 9, 1), 1'b0);
      repeat (3) step(1'b0, alu(11, 10, 9), 1'b0, 1'b1, st);
      issue(alu(11, 10, 9), 1'b0);
      repeat (3) issue(nop, 1'b0);
      // redirect with D moving, then during a branch interlock
      issue(beq(1, 2), 1'b1);
      issue(alu(12, 1, 1), 1'b0);
      step(1'b0, beq(12, 0), 1'b1, 1'b0, st);
      issue(beq(12, 0), 1'b1);
      repeat (3) issue(nop, 1'b0);
      // register zero never creates a dependence
      issue(alu(0, 1, 2), 1'b0); issue(alu(13, 0, 0), 1'b0);
      issue(lw(0, 1), 1'b0); issue(beq(0, 0), 1'b0);
      repeat (3) issue(nop, 1'b0);
      // reset with instructions in flight
      issue(alu(16, 1, 2), 1'b0); issue(lw(17, 1), 1'b0);
      step(1'b1, alu(18, 17, 16), 1'b0, 1'b0, st);
      issue(alu(18, 17, 16), 1'b0); issue(nop, 1'b0);

      // random traffic over a small tag set; D is held while stalled
      st = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (!st) begin
            cur.rs  = AW'($urandom_range(0, 3));
            cur.rt  = AW'($urandom_range(0, 3));
            cur.wr  = AW'($urandom_range(0, 3));
            cur.rsu = ($urandom_range(0, 3) != 0);
            cur.rtu = ($urandom_range(0, 3) != 0);
            cur.ld  = ($urandom_range(0, 3) == 0);
            cur.rw  = cur.ld || ($urandom_range(0, 3) != 0);
            cur.br  = !cur.ld && ($urandom_range(0, 4) == 0);
         end
         if (busy_left > 0) begin
            b = 1'b1;
            busy_left--;
         end else if ($urandom_range(0, 11) == 0) begin
            b = 1'b1;
            busy_left = int'($urandom_range(0, 3));
         end else begin
            b = 1'b0;
         end
         step(($urandom_range(0, 79) == 0), cur, ($urandom_range(0, 5) == 0), b, st);
      end

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order MIPS core: a generalised successor to the fixed five-stage hazard logic. It tracks destination/source register tags of every in-flight instruction from E to the last stage internally, so the datapath only supplies D-stage decode information. From these tags it derives per-stage stall and flush vectors, E-stage and D-stage (branch compare) forwarding selects, load-use and branch-operand interlocks, multi-cycle-unit (divider) back-pressure, and redirect flushes. Sits beside the datapath; drives every pipeline register's enable/clear.

## Interface
- NUM_STAGES, 5, pipeline depth including F (stage 0); D=1, E=2, last=writeback; legal 4..8.
- REG_AW, 5, register tag width.
- LOAD_STAGE, 3, last stage in which load data is NOT yet forwardable (data available from stage LOAD_STAGE+1); legal E..NUM_STAGES-2.
- FW, $clog2(NUM_STAGES-2), width of E forwarding select.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  REG_AW  D-stage source tags.
- id_rs_used, id_rt_used  in  1  source actually read.
- id_regwrite  in  1  D instruction writes a register.
- id_writereg  in  REG_AW  D destination tag (after rt/rd select).
- id_memtoreg  in  1  D instruction is a load.
- id_branch  in  1  D instruction compares operands in D.
- redirect  in  1  taken branch/jump resolved in D this cycle.
- ex_busy  in  1  multi-cycle unit in E not finished.
- stall  out  NUM_STAGES  bit s: hold stage-s register (bit 0 = PC).
- flush  out  NUM_STAGES  bit s: clear stage-s register at next edge.
- fwd_a_d, fwd_b_d  out  1  D compare operand from stage E+1 ALU result.
- fwd_a_e, fwd_b_e  out  FW  0 = register file value; d = stage E+d result.

## Operation
- Tracking entry per stage E..last: valid, regwrite, memtoreg, writereg, rs, rt (rs/rt = 0 when unused).
- Advance: entry s loads entry s-1 (E loads D inputs) when ~stall[s]; cleared (valid=0) when flush[s]; held when stall[s].
- Match(s, tag): valid[s] & regwrite[s] & tag != 0 & writereg[s] == tag.
- lwstall: D source (used) matches any stage s in E..LOAD_STAGE-1 with memtoreg.
- brstall: id_branch & source matches E, or matches stage in E+1..LOAD_STAGE with memtoreg.
- hzstall = lwstall | brstall: stall[0..1]=1, flush[E]=1.
- ex_busy: stall[0..E]=1, flush[E+1]=1; dominates hzstall (flush[E]=0 while busy).
- redirect & ~stall[1]: flush[1]=1. Ignored while D stalled.
- fwd_x_e: smallest d (1..last-E) with Match(E+d, rsE/rtE) and not (memtoreg & E+d <= LOAD_STAGE); 0 if none.
- fwd_x_d: Match(E+1, id_rs/id_rt) & ~memtoreg[E+1].
- Tag 0 never matches, never forwards, never stalls.

## Timing
- All outputs combinational from tracking registers and D inputs; zero latency.
- Tracking state updates on rising clk edge only.
- rst high: all valid cleared at the edge; while rst high stall = 0, flush = all ones, forwarding selects = 0.
- Reset mid-operation discards all in-flight entries; first instruction after release sees no hazards.
- Load-use costs exactly (LOAD_STAGE - E) bubbles at default params (1 bubble).
- ex_busy held N cycles: F/D/E frozen N cycles, N bubbles into E+1; release takes effect the same cycle ex_busy falls.

## Configuration
- PIPE_CTRL_DELAY_SLOT_EN defined: redirect never asserts flush[1]; the D-stage instruction after a branch (delay slot) executes.
- Undefined: redirect flushes D as above (no delay slot).

## Structure
- pipe_ctrl_pkg: stage index constants STG_F=0, STG_D=1, STG_E=2; typedef of tracking entry struct; parameter legality checks.
- One sub-module: pipe_ctrl_entry (one tracking register with enable/clear/sync reset), generated per stage E..last.

## Test plan
- Back-to-back add $3 then sub using $3 -> fwd_a_e=1 for sub in E; no stall; two-apart -> fwd_a_e=2.
- lw $5 then add using $5 -> one cycle stall[0..1]=1, flush[2]=1; then fwd=2 (from W).
- add $4 then beq $4,$0 -> one brstall cycle, then fwd_a_d=1; lw $4 then beq -> two stall cycles.
- ex_busy high 3 cycles -> stall[0..2]=1 for 3 cycles, flush[3]=1 each, state preserved.
- redirect with D unstalled -> flush[1]=1 (0 with PIPE_CTRL_DELAY_SLOT_EN); redirect during brstall -> flush[1]=0.
- Write to $0 followed by use of $0 -> fwd=0, no stall; rst mid-stream -> flush=all ones, valids clear next cycle.
